// File: rtl/spi_sample_reader_if.sv
// spi_sample_reader_if
//   Bundles the request/response handshake and the SPI pins of the
//   sample reader.
//   master modport : the reader itself (drives SPI clock/select, busy, rx_*)
//   slave modport  : the environment (drives start and spi_miso)
//   Signals: start, busy, spi_sck, spi_cs_n, spi_miso, rx_data, rx_valid
interface spi_sample_reader_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  start;
  logic                  busy;
  logic                  spi_sck;
  logic                  spi_cs_n;
  logic                  spi_miso;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;

  modport master (
    input  start, spi_miso,
    output busy, spi_sck, spi_cs_n, rx_data, rx_valid
  );

  modport slave (
    output start, spi_miso,
    input  busy, spi_sck, spi_cs_n, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_sample_reader.sv
// spi_sample_reader
//   SPI master receiver. Generates chip select and an idle-low serial clock,
//   samples spi_miso on each rising SCK edge (MSB first) and presents each
//   completed word on rx_data with a one-cycle rx_valid strobe. All outputs
//   come straight from flops.
//   Ports:
//     clk  - system clock, rising edge
//     rst  - asynchronous, active-high reset
//     bus  - master modport: start/busy handshake, SPI pins, rx_data/rx_valid
module spi_sample_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int CLK_DIV    = 2,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2,
  parameter int CS_IDLE    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  spi_sample_reader_if.master        bus
);

  // Phase counter must hold the longest of the timed phases.
  localparam int MAX_AB  = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int MAX_CD  = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
  localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW      = $clog2(CNT_MAX + 1);
  // Bit counter reaches DATA_WIDTH itself, so it needs one extra code.
  localparam int BW      = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_SCK_LO = 3'd2,
    S_SCK_HI = 3'd3,
    S_HOLD   = 3'd4,
    S_GAP    = 3'd5
  } state_t;

  state_t                state_r,    state_s;
  logic [CW-1:0]         cnt_r,      cnt_s;
  logic [BW-1:0]         bit_cnt_r,  bit_cnt_s;
  logic [DATA_WIDTH-1:0] sr_r,       sr_s;
  logic [DATA_WIDTH-1:0] rx_data_r,  rx_data_s;
  logic                  rx_valid_r, rx_valid_s;
  logic                  busy_r,     busy_s;
  logic                  sck_r,      sck_s;
  logic                  cs_n_r,     cs_n_s;

  // Next-state and next-output computation for every register.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r + CW'(1);
    bit_cnt_s  = bit_cnt_r;
    sr_s       = sr_r;
    rx_data_s  = rx_data_r;
    rx_valid_s = 1'b0;
    busy_s     = busy_r;
    sck_s      = sck_r;
    cs_n_s     = cs_n_r;

    case (state_r)
      S_IDLE: begin
        cnt_s = '0;
        if (bus.start) begin
          cs_n_s    = 1'b0;
          busy_s    = 1'b1;
          bit_cnt_s = '0;
          sr_s      = '0;
          state_s   = S_SETUP;
        end else begin
          state_s   = S_IDLE;
        end
      end

      S_SETUP: begin
        if (cnt_r == CW'(CS_SETUP - 1)) begin
          cnt_s   = '0;
          state_s = S_SCK_LO;
        end else begin
          state_s = S_SETUP;
        end
      end

      S_SCK_LO: begin
        // The slave changed data on the previous falling edge, so MISO has
        // been stable for CLK_DIV cycles when SCK is raised here.
        if (cnt_r == CW'(CLK_DIV - 1)) begin
          cnt_s     = '0;
          sck_s     = 1'b1;
          sr_s      = {sr_r[DATA_WIDTH-2:0], bus.spi_miso};
          bit_cnt_s = bit_cnt_r + BW'(1);
          state_s   = S_SCK_HI;
        end else begin
          state_s   = S_SCK_LO;
        end
      end

      S_SCK_HI: begin
        if (cnt_r == CW'(CLK_DIV - 1)) begin
          cnt_s = '0;
          sck_s = 1'b0;
          if (bit_cnt_r == BW'(DATA_WIDTH)) begin
            state_s = S_HOLD;
          end else begin
            state_s = S_SCK_LO;
          end
        end else begin
          state_s = S_SCK_HI;
        end
      end

      S_HOLD: begin
        if (cnt_r == CW'(CS_HOLD - 1)) begin
          cnt_s      = '0;
          cs_n_s     = 1'b1;
          rx_data_s  = sr_r;
          rx_valid_s = 1'b1;
          state_s    = S_GAP;
        end else begin
          state_s    = S_HOLD;
        end
      end

      S_GAP: begin
        if (cnt_r == CW'(CS_IDLE - 1)) begin
          cnt_s   = '0;
          busy_s  = 1'b0;
          state_s = S_IDLE;
        end else begin
          state_s = S_GAP;
        end
      end

      default: begin
        // Unreachable encodings fall back to a safe idle bus.
        state_s = S_IDLE;
        cnt_s   = '0;
        sck_s   = 1'b0;
        cs_n_s  = 1'b1;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset puts the bus idle immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_IDLE;
      cnt_r      <= '0;
      bit_cnt_r  <= '0;
      sr_r       <= '0;
      rx_data_r  <= '0;
      rx_valid_r <= 1'b0;
      busy_r     <= 1'b0;
      sck_r      <= 1'b0;
      cs_n_r     <= 1'b1;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      bit_cnt_r  <= bit_cnt_s;
      sr_r       <= sr_s;
      rx_data_r  <= rx_data_s;
      rx_valid_r <= rx_valid_s;
      busy_r     <= busy_s;
      sck_r      <= sck_s;
      cs_n_r     <= cs_n_s;
    end
  end

  assign bus.busy     = busy_r;
  assign bus.spi_sck  = sck_r;
  assign bus.spi_cs_n = cs_n_r;
  assign bus.rx_data  = rx_data_r;
  assign bus.rx_valid = rx_valid_r;

endmodule

// File: tb/tb_spi_sample_reader.sv
// tb_spi_sample_reader
//   Drives two reader instances (default timing and the fastest timing) with
//   SPI slave models that shift a queued word out on falling SCK, and checks
//   words, strobes and chip-select/clock timing against expected values.
module tb_spi_sample_reader;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  spi_sample_reader_if #(.DATA_WIDTH(16)) bus_a ();
  spi_sample_reader_if #(.DATA_WIDTH(16)) bus_b ();

  spi_sample_reader #(.DATA_WIDTH(16), .CLK_DIV(2), .CS_SETUP(2), .CS_HOLD(2), .CS_IDLE(4))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  spi_sample_reader #(.DATA_WIDTH(16), .CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .CS_IDLE(1))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- slave models ----------------
  logic [15:0] slv_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] sa_word = 16'h0000;
  int          sa_idx  = 0;
  bit          sa_act  = 1'b0;
  logic [15:0] sb_word = 16'h0000;
  int          sb_idx  = 0;
  bit          sb_act  = 1'b0;

  always @(posedge bus_a.spi_cs_n or negedge bus_a.spi_cs_n or negedge bus_a.spi_sck) begin
    if (bus_a.spi_cs_n !== 1'b0) begin
      sa_act = 1'b0;
    end else if (!sa_act) begin
      sa_act = 1'b1;
      sa_idx = 15;
      if (slv_q.size() > 0) sa_word = slv_q.pop_front();
      else sa_word = 16'hDEAD;
    end else if (sa_idx > 0) begin
      sa_idx--;
    end
  end
  assign bus_a.spi_miso = sa_word[sa_idx[3:0]];

  always @(posedge bus_b.spi_cs_n or negedge bus_b.spi_cs_n or negedge bus_b.spi_sck) begin
    if (bus_b.spi_cs_n !== 1'b0) begin
      sb_act = 1'b0;
    end else if (!sb_act) begin
      sb_act  = 1'b1;
      sb_idx  = 15;
      sb_word = 16'h1234;
    end else if (sb_idx > 0) begin
      sb_idx--;
    end
  end
  assign bus_b.spi_miso = sb_word[sb_idx[3:0]];

  // ---------------- monitor for instance A ----------------
  int   cyc = 0, valid_cnt = 0, txn_cnt = 0;
  int   rises_txn = 0, last_rises = 0, last_rise_cyc = 0, per_min = 1000, per_max = 0;
  int   cs_low_run = 0, last_cs_low = 0, cs_high_run = 0;
  int   busy_run = 0, last_busy = 0;
  int   gap_q[$];
  logic p_cs = 1'b1, p_sck = 1'b0, p_busy = 1'b0, p_valid = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (p_sck === 1'b0 && bus_a.spi_sck === 1'b1) begin
      check("sck_rise_needs_cs", 32'(bus_a.spi_cs_n), 32'd0);
      rises_txn++;
      if (rises_txn > 1) begin
        if (cyc - last_rise_cyc < per_min) per_min = cyc - last_rise_cyc;
        if (cyc - last_rise_cyc > per_max) per_max = cyc - last_rise_cyc;
      end
      last_rise_cyc = cyc;
    end
    if (bus_a.spi_cs_n === 1'b0) begin
      if (p_cs === 1'b1) begin
        txn_cnt++;
        gap_q.push_back(cs_high_run);
        cs_low_run = 0;
        rises_txn  = 0;
        per_min    = 1000;
        per_max    = 0;
      end
      cs_low_run++;
    end else begin
      if (p_cs === 1'b0) begin
        last_cs_low = cs_low_run;
        last_rises  = rises_txn;
        rises_txn   = 0;
        cs_high_run = 0;
      end
      cs_high_run++;
    end
    if (bus_a.busy === 1'b1) begin
      if (p_busy !== 1'b1) busy_run = 0;
      busy_run++;
    end else if (p_busy === 1'b1) begin
      last_busy = busy_run;
    end
    if (bus_a.rx_valid === 1'b1) begin
      valid_cnt++;
      check("valid_one_cycle", 32'(p_valid), 32'd0);
      check("valid_at_cs_rise", 32'({p_cs, bus_a.spi_cs_n}), 32'd1);
      if (exp_q.size() > 0) check("rx_data", 32'(bus_a.rx_data), 32'(exp_q.pop_front()));
      else check("rx_unexpected_word", 32'(exp_q.size()), 32'd1);
    end
    p_cs    = bus_a.spi_cs_n;
    p_sck   = bus_a.spi_sck;
    p_busy  = bus_a.busy;
    p_valid = bus_a.rx_valid;
  end

  // ---------------- helpers ----------------
  task automatic pulse_a();
    @(negedge clk) bus_a.start = 1'b1;
    @(negedge clk) bus_a.start = 1'b0;
  endtask

  task automatic wait_a_idle(input string tag);
    int n = 0;
    while (bus_a.busy !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < 3000), 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_valid_after(input int base, input string tag);
    int n = 0;
    while (valid_cnt <= base && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < 3000), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  int          base, tbase, bad, n;
  logic [15:0] w;
  int          lo, bz, ri, pmn, pmx, lrc, vc;
  logic        ps;
  logic [15:0] dat;

  initial begin
    rst = 1'b1;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    #1;
    check("rst_cs_n", 32'(bus_a.spi_cs_n), 32'd1);
    check("rst_sck", 32'(bus_a.spi_sck), 32'd0);
    check("rst_busy", 32'(bus_a.busy), 32'd0);
    check("rst_valid", 32'(bus_a.rx_valid), 32'd0);
    check("rst_rx_data", 32'(bus_a.rx_data), 32'd0);
    check("rst_b_cs_n", 32'(bus_b.spi_cs_n), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Idle: nothing may move without a start.
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus_a.spi_sck !== 1'b0 || bus_a.spi_cs_n !== 1'b1 || bus_a.rx_valid !== 1'b0) bad++;
    end
    check("idle_quiet", 32'(bad), 32'd0);

    // Single word 0xA5C3.
    base = valid_cnt;
    slv_q.push_back(16'hA5C3);
    exp_q.push_back(16'hA5C3);
    pulse_a();
    wait_a_idle("single_timeout");
    check("single_valid_cnt", 32'(valid_cnt - base), 32'd1);
    check("single_rx_data", 32'(bus_a.rx_data), 32'hA5C3);
    check("single_cs_low", 32'(last_cs_low), 32'd68);
    check("single_busy", 32'(last_busy), 32'd72);
    check("single_rises", 32'(last_rises), 32'd16);
    check("single_per_min", 32'(per_min), 32'd4);
    check("single_per_max", 32'(per_max), 32'd4);

    // Back to back with start held high.
    base = valid_cnt;
    gap_q.delete();
    slv_q.push_back(16'h8001); exp_q.push_back(16'h8001);
    slv_q.push_back(16'h0000); exp_q.push_back(16'h0000);
    slv_q.push_back(16'hFFFF); exp_q.push_back(16'hFFFF);
    slv_q.push_back(16'h7FFE); exp_q.push_back(16'h7FFE);
    @(negedge clk) bus_a.start = 1'b1;
    wait_valid_after(base + 3, "b2b_timeout");
    bus_a.start = 1'b0;
    wait_a_idle("b2b_idle_timeout");
    check("b2b_valid_cnt", 32'(valid_cnt - base), 32'd4);
    check("b2b_txn_cnt", 32'(gap_q.size()), 32'd4);
    for (int i = 1; i < 4; i++) begin
      if (i < gap_q.size()) check("b2b_cs_gap", 32'(gap_q[i]), 32'd5);
    end
    check("b2b_rx_last", 32'(bus_a.rx_data), 32'h7FFE);
    check("b2b_exp_drained", 32'(exp_q.size()), 32'd0);

    // Start pulses while busy must be ignored.
    base  = valid_cnt;
    tbase = txn_cnt;
    slv_q.push_back(16'h3C96);
    exp_q.push_back(16'h3C96);
    pulse_a();
    n = 0;
    while (rises_txn < 5 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("bit5_timeout", 32'(n < 500), 32'd1);
    pulse_a();
    wait_valid_after(base, "gap_timeout");
    pulse_a();
    wait_a_idle("ign_idle_timeout");
    repeat (20) @(negedge clk);
    check("ign_valid_cnt", 32'(valid_cnt - base), 32'd1);
    check("ign_txn_cnt", 32'(txn_cnt - tbase), 32'd1);
    check("ign_busy_len", 32'(last_busy), 32'd72);
    check("ign_cs_low", 32'(last_cs_low), 32'd68);
    check("ign_busy_now", 32'(bus_a.busy), 32'd0);

    // Asynchronous reset after the 7th rising SCK edge.
    base = valid_cnt;
    slv_q.push_back(16'hBEEF);
    pulse_a();
    n = 0;
    while (rises_txn < 7 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("bit7_timeout", 32'(n < 500), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_cs_n", 32'(bus_a.spi_cs_n), 32'd1);
    check("arst_sck", 32'(bus_a.spi_sck), 32'd0);
    check("arst_busy", 32'(bus_a.busy), 32'd0);
    check("arst_rx_data", 32'(bus_a.rx_data), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("arst_no_valid", 32'(valid_cnt - base), 32'd0);
    slv_q.push_back(16'h5A0F);
    exp_q.push_back(16'h5A0F);
    pulse_a();
    wait_a_idle("post_rst_timeout");
    check("post_rst_valid", 32'(valid_cnt - base), 32'd1);
    check("post_rst_rx", 32'(bus_a.rx_data), 32'h5A0F);

    // Random words with random idle spacing.
    for (int k = 0; k < 6; k++) begin
      w = 16'($urandom);
      slv_q.push_back(w);
      exp_q.push_back(w);
      repeat ($urandom_range(0, 10)) @(negedge clk);
      pulse_a();
      wait_a_idle("rand_timeout");
      check("rand_rx", 32'(bus_a.rx_data), 32'(w));
      check("rand_cs_low", 32'(last_cs_low), 32'd68);
      check("rand_rises", 32'(last_rises), 32'd16);
    end
    check("exp_drained", 32'(exp_q.size()), 32'd0);

    // Fastest timing instance, word 0x1234.
    lo = 0; bz = 0; ri = 0; pmn = 1000; pmx = 0; lrc = 0; vc = 0; dat = 16'h0000;
    ps = bus_b.spi_sck;
    @(negedge clk) bus_b.start = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i == 0) bus_b.start = 1'b0;
      if (bus_b.spi_cs_n === 1'b0) lo++;
      if (bus_b.busy === 1'b1) bz++;
      if (ps === 1'b0 && bus_b.spi_sck === 1'b1) begin
        ri++;
        if (ri > 1) begin
          if (i - lrc < pmn) pmn = i - lrc;
          if (i - lrc > pmx) pmx = i - lrc;
        end
        lrc = i;
      end
      if (bus_b.rx_valid === 1'b1) begin
        vc++;
        dat = bus_b.rx_data;
      end
      ps = bus_b.spi_sck;
    end
    check("b_cs_low", 32'(lo), 32'd34);
    check("b_busy", 32'(bz), 32'd35);
    check("b_rises", 32'(ri), 32'd16);
    check("b_per_min", 32'(pmn), 32'd2);
    check("b_per_max", 32'(pmx), 32'd2);
    check("b_valid_cnt", 32'(vc), 32'd1);
    check("b_rx_data", 32'(dat), 32'h1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
